// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: access-size encodings, XLEN,
// FSM states and the packed queue entry. Optional feature macro: LSQ_BUS_ERR_EN.
package lsq_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    LSQ_IDLE = 2'd0,
    LSQ_REQ  = 2'd1,
    LSQ_RSP  = 2'd2
  } lsq_state_e;

  typedef struct packed {
    logic               write;
    logic [1:0]         hpl;
    logic [2:0]         funct3;
    logic [4:0]         regd;
    logic [RV_XLEN-1:0] data;
    logic [RV_XLEN-1:0] addr;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_fifo.sv
// Synchronous FIFO holding queue entries; pointers wrap naturally and
// full_o is derived from the occupancy count alone.
module lsq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     resetb_i,
  input  logic                     clk_en_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = clk_en_i & push_i & ~full_o;
  assign do_pop  = clk_en_i & pop_i & ~empty_o;

  always_comb begin
    wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lsq.sv
// Load/store queue: in-order issue over a single-outstanding data bus, with
// store alignment and load extension. Optional feature macro: LSQ_BUS_ERR_EN.
module lsq
  import lsq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               resetb_i,
  input  logic               clk_en_i,
  output logic               full_o,
  input  logic               lq_wr_i,
  input  logic               sq_wr_i,
  input  logic [1:0]         hpl_i,
  input  logic [2:0]         funct3_i,
  input  logic [4:0]         regd_addr_i,
  input  logic [RV_XLEN-1:0] regs2_data_i,
  input  logic [RV_XLEN-1:0] addr_i,
  output logic               dreq_valid_o,
  input  logic               dreq_ready_i,
  output logic               dreq_write_o,
  output logic [1:0]         dreq_hpl_o,
  output logic [RV_XLEN-1:0] dreq_addr_o,
  output logic [3:0]         dreq_be_o,
  output logic [RV_XLEN-1:0] dreq_data_o,
  input  logic               drsp_valid_i,
  input  logic [RV_XLEN-1:0] drsp_data_i,
`ifdef LSQ_BUS_ERR_EN
  input  logic               drsp_err_i,
  output logic               bus_err_o,
  output logic [RV_XLEN-1:0] bus_err_addr_o,
`endif
  output logic               wb_wr_o,
  output logic [4:0]         wb_addr_o,
  output logic [RV_XLEN-1:0] wb_data_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [RV_XLEN-1:0] store_align(input logic [2:0] f3,
                                                     input logic [RV_XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   store_align = {4{d[7:0]}};
      2'b01:   store_align = {2{d[15:0]}};
      default: store_align = d;
    endcase
  endfunction

  function automatic logic [RV_XLEN-1:0] load_extend(input logic [2:0] f3,
                                                     input logic [1:0] a,
                                                     input logic [RV_XLEN-1:0] w);
    logic [RV_XLEN-1:0] s;
    s = w >> {a, 3'b000};
    case (f3)
      LS_B:    load_extend = {{24{s[7]}}, s[7:0]};
      LS_H:    load_extend = {{16{s[15]}}, s[15:0]};
      LS_BU:   load_extend = {24'd0, s[7:0]};
      LS_HU:   load_extend = {16'd0, s[15:0]};
      default: load_extend = s;
    endcase
  endfunction

  lsq_state_e         state_q, state_d;
  lsq_entry_t         push_ent, head;
  logic               empty, push_acc, pop, more, rsp_err, wb_fire;
  logic [CW-1:0]      count;
  logic               wb_wr_q;
  logic [4:0]         wb_addr_q;
  logic [RV_XLEN-1:0] wb_data_q;

  assign push_ent = '{write: sq_wr_i, hpl: hpl_i, funct3: funct3_i, regd: regd_addr_i,
                      data: regs2_data_i, addr: addr_i};

  lsq_fifo #(.DEPTH(DEPTH), .WIDTH($bits(lsq_entry_t))) u_fifo (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .clk_en_i (clk_en_i),
    .push_i   (lq_wr_i | sq_wr_i),
    .pop_i    (pop),
    .wdata_i  (push_ent),
    .rdata_o  (head),
    .full_o   (full_o),
    .empty_o  (empty),
    .count_o  (count)
  );

`ifdef LSQ_BUS_ERR_EN
  assign rsp_err = drsp_err_i;
`else
  assign rsp_err = 1'b0;
`endif

  assign push_acc = clk_en_i & (lq_wr_i | sq_wr_i) & ~full_o;
  assign pop      = clk_en_i & (state_q == LSQ_RSP) & drsp_valid_i;
  // An accepted push in the pop cycle keeps the queue non-empty.
  assign more     = (count > CW'(1)) | push_acc;
  assign wb_fire  = pop & ~head.write & ~rsp_err;

  always_comb begin
    state_d      = state_q;
    dreq_valid_o = 1'b0;
    dreq_write_o = 1'b0;
    dreq_hpl_o   = '0;
    dreq_addr_o  = '0;
    dreq_be_o    = '0;
    dreq_data_o  = '0;
    case (state_q)
      LSQ_IDLE: if (!empty) state_d = LSQ_REQ;
      LSQ_REQ: begin
        dreq_valid_o = 1'b1;
        dreq_write_o = head.write;
        dreq_hpl_o   = head.hpl;
        dreq_addr_o  = {head.addr[RV_XLEN-1:2], 2'b00};
        dreq_be_o    = byte_en(head.funct3, head.addr[1:0]);
        dreq_data_o  = store_align(head.funct3, head.data);
        if (dreq_ready_i) state_d = LSQ_RSP;
      end
      LSQ_RSP: if (drsp_valid_i) state_d = more ? LSQ_REQ : LSQ_IDLE;
      default: state_d = LSQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= LSQ_IDLE;
      wb_wr_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      wb_wr_q <= wb_fire;
      if (wb_fire) begin
        wb_addr_q <= head.regd;
        wb_data_q <= load_extend(head.funct3, head.addr[1:0], drsp_data_i);
      end
    end
  end

  assign wb_wr_o   = wb_wr_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;

`ifdef LSQ_BUS_ERR_EN
  logic               bus_err_q;
  logic [RV_XLEN-1:0] bus_err_addr_q;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= '0;
    end else if (clk_en_i) begin
      bus_err_q <= pop & drsp_err_i;
      if (pop & drsp_err_i) bus_err_addr_q <= head.addr;
    end
  end

  assign bus_err_o      = bus_err_q;
  assign bus_err_addr_o = bus_err_addr_q;
`endif

  a_single_push: assert property (@(posedge clk_i) disable iff (!resetb_i)
                                  !(lq_wr_i && sq_wr_i));

endmodule

// File: tb/tb_lsq.sv
// Bench for lsq: table-driven single accesses plus full, reset, co-push and
// clock-enable sequences; expected requests and write-backs kept in a queue.
module tb_lsq;
  import lsq_pkg::*;

  logic        clk_i = 1'b0;
  logic        resetb_i = 1'b1;
  logic        clk_en_i = 1'b0;
  logic        full_o;
  logic        lq_wr_i = 1'b0, sq_wr_i = 1'b0;
  logic [1:0]  hpl_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  regd_addr_i = '0;
  logic [31:0] regs2_data_i = '0, addr_i = '0;
  logic        dreq_valid_o, dreq_ready_i = 1'b0, dreq_write_o;
  logic [1:0]  dreq_hpl_o;
  logic [31:0] dreq_addr_o, dreq_data_o;
  logic [3:0]  dreq_be_o;
  logic        drsp_valid_i = 1'b0;
  logic [31:0] drsp_data_i = '0;
  logic        wb_wr_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
`ifdef LSQ_BUS_ERR_EN
  logic        drsp_err_i = 1'b0;
  logic        bus_err_o;
  logic [31:0] bus_err_addr_o;
`endif

  lsq #(.DEPTH(4)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i), .full_o(full_o),
    .lq_wr_i(lq_wr_i), .sq_wr_i(sq_wr_i), .hpl_i(hpl_i), .funct3_i(funct3_i),
    .regd_addr_i(regd_addr_i), .regs2_data_i(regs2_data_i), .addr_i(addr_i),
    .dreq_valid_o(dreq_valid_o), .dreq_ready_i(dreq_ready_i), .dreq_write_o(dreq_write_o),
    .dreq_hpl_o(dreq_hpl_o), .dreq_addr_o(dreq_addr_o), .dreq_be_o(dreq_be_o),
    .dreq_data_o(dreq_data_o), .drsp_valid_i(drsp_valid_i), .drsp_data_i(drsp_data_i),
`ifdef LSQ_BUS_ERR_EN
    .drsp_err_i(drsp_err_i), .bus_err_o(bus_err_o), .bus_err_addr_o(bus_err_addr_o),
`endif
    .wb_wr_o(wb_wr_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          store;
    logic [1:0]  hpl;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] rsp;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  vec_t cur;
  vec_t tbl[10];
  vec_t fv[5];
  vec_t rv[3];
  vec_t v;

  function automatic vec_t mk(input bit st, input logic [1:0] hp, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] d, input logic [31:0] a,
                              input logic [31:0] r, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] wb);
    vec_t t;
    t.store = st; t.hpl = hp; t.f3 = f3; t.rd = rd; t.data = d; t.addr = a;
    t.rsp = r; t.be = be; t.wdata = wd; t.wb = wb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input vec_t p);
    bit was_full;
    was_full = full_o;
    lq_wr_i = !p.store; sq_wr_i = p.store; hpl_i = p.hpl; funct3_i = p.f3;
    regd_addr_i = p.rd; regs2_data_i = p.data; addr_i = p.addr;
    step();
    lq_wr_i = 1'b0; sq_wr_i = 1'b0;
    if (!was_full) exp_q.push_back(p);
  endtask

  task automatic req_phase();
    int n;
    n = 0;
    while (dreq_valid_o !== 1'b1 && n < 50) begin step(); n++; end
    chk("req_valid", 32'(dreq_valid_o), 32'd1);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_underflow: request seen with no entry expected");
      return;
    end
    cur = exp_q.pop_front();
    chk("req_write", 32'(dreq_write_o), 32'(cur.store));
    chk("req_hpl",   32'(dreq_hpl_o), 32'(cur.hpl));
    chk("req_addr",  dreq_addr_o, cur.addr & 32'hFFFF_FFFC);
    chk("req_be",    32'(dreq_be_o), 32'(cur.be));
    if (cur.store) chk("req_data", dreq_data_o, cur.wdata);
    step();
    chk("req_hold_valid", 32'(dreq_valid_o), 32'd1);
    chk("req_hold_addr", dreq_addr_o, cur.addr & 32'hFFFF_FFFC);
    dreq_ready_i = 1'b1;
    step();
    dreq_ready_i = 1'b0;
    chk("req_drop", 32'(dreq_valid_o), 32'd0);
  endtask

  task automatic rsp_phase(input bit err, input bit co, input vec_t cv);
    step();
    chk("rsp_no_early_wb", 32'(wb_wr_o), 32'd0);
    if (co) begin
      lq_wr_i = !cv.store; sq_wr_i = cv.store; hpl_i = cv.hpl; funct3_i = cv.f3;
      regd_addr_i = cv.rd; regs2_data_i = cv.data; addr_i = cv.addr;
      exp_q.push_back(cv);
    end
    drsp_valid_i = 1'b1; drsp_data_i = cur.rsp;
`ifdef LSQ_BUS_ERR_EN
    drsp_err_i = err;
`endif
    step();
    drsp_valid_i = 1'b0; lq_wr_i = 1'b0; sq_wr_i = 1'b0;
`ifdef LSQ_BUS_ERR_EN
    drsp_err_i = 1'b0;
    chk("bus_err", 32'(bus_err_o), 32'(err));
    if (err) chk("bus_err_addr", bus_err_addr_o, cur.addr);
`endif
    if (!cur.store && !err) begin
      chk("wb_wr", 32'(wb_wr_o), 32'd1);
      chk("wb_addr", 32'(wb_addr_o), 32'(cur.rd));
      chk("wb_data", wb_data_o, cur.wb);
    end else begin
      chk("wb_none", 32'(wb_wr_o), 32'd0);
    end
    step();
    chk("wb_pulse_end", 32'(wb_wr_o), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            st hpl f3     rd  data          addr          rsp           be       wdata         wb
    tbl[0] = mk(0, 2'd3, LS_W,  5, 32'h0,        32'h100, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF);
    tbl[1] = mk(1, 2'd0, LS_B,  0, 32'h000000A5, 32'h103, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0);
    tbl[2] = mk(0, 2'd1, LS_B,  6, 32'h0,        32'h102, 32'h80FF7F00, 4'b0100, 32'h0,        32'hFFFFFFFF);
    tbl[3] = mk(0, 2'd1, LS_HU, 7, 32'h0,        32'h102, 32'h80FF7F00, 4'b1100, 32'h0,        32'h000080FF);
    tbl[4] = mk(0, 2'd2, LS_H,  8, 32'h0,        32'h100, 32'h12348001, 4'b0011, 32'h0,        32'hFFFF8001);
    tbl[5] = mk(0, 2'd0, LS_BU, 9, 32'h0,        32'h101, 32'h12348001, 4'b0010, 32'h0,        32'h00000080);
    tbl[6] = mk(1, 2'd3, LS_H,  0, 32'h0000BEEF, 32'h206, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0);
    tbl[7] = mk(1, 2'd1, LS_W,  0, 32'h12345678, 32'h30C, 32'h0,        4'b1111, 32'h12345678, 32'h0);
    tbl[8] = mk(0, 2'd0, LS_W,  0, 32'h0,        32'h040, 32'hCAFEF00D, 4'b1111, 32'h0,        32'hCAFEF00D);
    tbl[9] = mk(0, 2'd2, LS_B,  1, 32'h0,        32'h043, 32'h7F000000, 4'b1000, 32'h0,        32'h0000007F);
    for (int i = 0; i < 5; i++)
      fv[i] = mk(0, 2'd0, LS_W, 5'(10 + i), 32'h0, 32'h500 + 32'(4 * i), 32'hA0000000 + 32'(i),
                 4'b1111, 32'h0, 32'hA0000000 + 32'(i));
    for (int i = 0; i < 3; i++)
      rv[i] = mk(0, 2'd0, LS_W, 5'(20 + i), 32'h0, 32'h700 + 32'(4 * i), 32'h0,
                 4'b1111, 32'h0, 32'h0);

    // Reset state
    #1 resetb_i = 1'b0;
    #2;
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_dreq_valid", 32'(dreq_valid_o), 32'd0);
    chk("rst_dreq_addr", dreq_addr_o, 32'd0);
    chk("rst_dreq_be", 32'(dreq_be_o), 32'd0);
    chk("rst_wb_wr", 32'(wb_wr_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    step(); step();
    resetb_i = 1'b1;
    clk_en_i = 1'b1;
    step();

    // Single accesses
    for (int i = 0; i < 10; i++) begin
      push(tbl[i]);
      req_phase();
      rsp_phase(1'b0, 1'b0, tbl[0]);
    end

    // Fill to full with the bus stalled, then drain in order
    for (int i = 0; i < 4; i++) push(fv[i]);
    chk("full_after_4", 32'(full_o), 32'd1);
    push(fv[4]);
    chk("full_after_5th", 32'(full_o), 32'd1);
    req_phase();
    rsp_phase(1'b0, 1'b0, tbl[0]);
    chk("full_drop", 32'(full_o), 32'd0);
    for (int i = 1; i < 4; i++) begin
      req_phase();
      rsp_phase(1'b0, 1'b0, tbl[0]);
    end
    repeat (8) step();
    chk("fifth_ignored", 32'(dreq_valid_o), 32'd0);

    // Reset while waiting for a response with three entries queued
    for (int i = 0; i < 3; i++) push(rv[i]);
    req_phase();
    #1 resetb_i = 1'b0;
    #1;
    chk("mid_rst_dreq_valid", 32'(dreq_valid_o), 32'd0);
    chk("mid_rst_wb_data", wb_data_o, 32'd0);
    chk("mid_rst_wb_addr", 32'(wb_addr_o), 32'd0);
    chk("mid_rst_full", 32'(full_o), 32'd0);
    exp_q.delete();
    step(); step();
    resetb_i = 1'b1;
    repeat (6) step();
    chk("flushed_no_req", 32'(dreq_valid_o), 32'd0);
    v = mk(0, 2'd1, LS_W, 3, 32'h0, 32'h600, 32'h11112222, 4'b1111, 32'h0, 32'h11112222);
    push(v);
    req_phase();
    rsp_phase(1'b0, 1'b0, tbl[0]);

    // Push in the same cycle as a pop
    v = mk(0, 2'd0, LS_W, 21, 32'h0, 32'h800, 32'h5555AAAA, 4'b1111, 32'h0, 32'h5555AAAA);
    push(v);
    req_phase();
    v = mk(0, 2'd2, LS_H, 22, 32'h0, 32'h806, 32'h13578000, 4'b1100, 32'h0, 32'h00001357);
    rsp_phase(1'b0, 1'b1, v);
    req_phase();
    rsp_phase(1'b0, 1'b0, tbl[0]);
    repeat (6) step();
    chk("copush_drained", 32'(dreq_valid_o), 32'd0);

    // Clock enable low blocks a push
    clk_en_i = 1'b0;
    lq_wr_i = 1'b1; funct3_i = LS_W; addr_i = 32'h900; regd_addr_i = 5'd2;
    step();
    lq_wr_i = 1'b0;
    clk_en_i = 1'b1;
    repeat (5) step();
    chk("clk_en_blocks_push", 32'(dreq_valid_o), 32'd0);

`ifdef LSQ_BUS_ERR_EN
    v = mk(0, 2'd0, LS_W, 4, 32'h0, 32'h200, 32'hBADBAD00, 4'b1111, 32'h0, 32'h0);
    push(v);
    req_phase();
    rsp_phase(1'b1, 1'b0, tbl[0]);
    repeat (4) step();
    chk("err_popped", 32'(dreq_valid_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsq.md
Name: lsq

Overview:
- Load/store queue directly downstream of the execute stage.
- Buffers committed loads and stores in program order and issues them one at a time over the data-bus request/response interface.
- Aligns store data and generates byte enables.
- Extracts and sign/zero-extends load data and writes it back to the register file.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- resetb_i  in  1  reset; asynchronous, active-low
- clk_en_i  in  1  global clock enable; all state holds while low
- full_o  in/out: out  1  queue full (count==DEPTH); combinational from count only
- lq_wr_i  in  1  push load entry
- sq_wr_i  in  1  push store entry
- hpl_i  in  2  privilege level of the pushed access
- funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- regd_addr_i  in  5  load destination register
- regs2_data_i  in  32  store data
- addr_i  in  32  effective byte address
- dreq_valid_o  out  1  bus request valid
- dreq_ready_i  in  1  bus request accepted
- dreq_write_o  out  1  1=store, 0=load
- dreq_hpl_o  out  2  request privilege level
- dreq_addr_o  out  32  address, word-aligned ({addr[31:2],2'b00})
- dreq_be_o  out  4  byte enables
- dreq_data_o  out  32  aligned store data
- drsp_valid_i  in  1  response valid (one per accepted request)
- drsp_data_i  in  32  load response word
- wb_wr_o  out  1  register-file write strobe (single-cycle pulse)
- wb_addr_o  out  5  write-back register
- wb_data_o  out  32  write-back data

Behaviour:
- Reset values: all outputs 0; queue empty; FSM in IDLE.
- Push:
  - Occurs on clk_en_i & (lq_wr_i|sq_wr_i) & ~full_o; one entry stored.
  - A push while full is ignored; the execute stage stalls on full_o.
  - lq_wr_i & sq_wr_i together is illegal; covered by an assertion in simulation.
- Ordering: single FIFO; loads and stores retire strictly in push order.
- FSM states:
  - IDLE: go to REQ when the queue is non-empty.
  - REQ: dreq_valid_o=1 with head-entry fields. On dreq_ready_i go to RSP. Request fields stay stable until accepted.
  - RSP: wait for drsp_valid_i; then pop the head. Go to REQ if more entries remain after the pop, else IDLE.
- Latency and throughput:
  - Push at cycle N gives dreq_valid_o at N+1 at the earliest.
  - At most one outstanding request.
  - A store also waits for its response before it retires.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Store data: B replicates the byte x4; H replicates the halfword x2; W passes through.
- Load data:
  - Shift drsp_data_i right by addr[1:0]*8.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Write-back:
  - wb_wr_o, wb_addr_o and wb_data_o are registered.
  - wb_wr_o pulses one cycle after the drsp_valid_i of a load.
  - Stores produce no write-back.
  - A load to x0 still pulses wb_wr_o; the register file ignores x0.
- Simultaneous push and pop: allowed; count is unchanged.
- Full boundary: full_o does not anticipate a pop.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally.
- Count width: log2(DEPTH)+1 bits.
- Reset mid-operation: the queue is flushed and any outstanding response is forgotten. The bus is reset by the same resetb_i.
- Misalignment was already trapped upstream; entries are assumed aligned per size.

Optional Feature:
- Macro: LSQ_BUS_ERR_EN.
- With the macro:
  - Adds input drsp_err_i (1) and output bus_err_o (1), plus output bus_err_addr_o (32).
  - A response with drsp_err_i=1 suppresses the load write-back.
  - It also pulses bus_err_o (registered, same timing as wb_wr_o) and reports the faulting byte address.
  - The entry is still popped.
- Without the macro: these ports are absent, and every response is treated as successful.

Decomposition:
- Shared package/defines (riscv_defs):
  - funct3 size encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU).
  - `RV_XLEN.
  - LSQ FSM state encodings.
- Sub-module lsq_fifo:
  - Parameterised synchronous FIFO (DEPTH, WIDTH).
  - Push, pop, head data, full/empty.
  - Holds the packed entry {write, hpl, funct3, regd, data, addr}.

Test Plan:
- Push LW x5 @0x100, response 0xDEADBEEF -> dreq be=1111, addr=0x100; wb_wr_o with x5=0xDEADBEEF one cycle after the response.
- Push SB @0x103 data 0x000000A5 -> dreq_write_o=1, be=1000, data=0xA5A5A5A5, addr=0x100; no write-back.
- LB @0x102 then LHU @0x102, response 0x80FF7F00 -> x=0xFFFFFFFF, then 0x000080FF.
- Push 4 entries with dreq_ready_i=0 -> full_o=1 after the 4th; a 5th push is ignored. Release ready and return responses -> entries retire in order; full_o drops after the first pop.
- Assert resetb_i low while in RSP with 3 entries -> all outputs 0, queue empty; after reset the next push issues normally.
- LSQ_BUS_ERR_EN: LW with drsp_err_i=1 @0x200 -> no wb_wr_o; bus_err_o pulses with bus_err_addr_o=0x200.
